// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types and defaults for the SL811 / DM9000 external data bus arbiter.
package ext_bus_arbiter_pkg;

    typedef logic       Bit_t;
    typedef logic [7:0] Byte_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_USB  = 2'd1,
        OWNER_ETH  = 2'd2
    } BusOwner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_USB = 2'd1,
        GNT_ETH = 2'd2,
        TURN    = 2'd3
    } arb_state_e;

    localparam int unsigned EXT_BUS_TURNAROUND = 2;
    localparam int unsigned EXT_BUS_MAX_HOLD   = 64;

endpackage

// File: rtl/ext_bus_arbiter.sv
// Grants the shared 8-bit pad bus to the USB or Ethernet controller, with a
// bus-undriven turnaround window between owners and a per-grant watchdog.
module ext_bus_arbiter
    import ext_bus_arbiter_pkg::*;
#(
    parameter int unsigned TURNAROUND_CYCLES = EXT_BUS_TURNAROUND,
    parameter int unsigned MAX_HOLD_CYCLES   = EXT_BUS_MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_req,
    input  logic       usb_done,
    output logic       usb_gnt,
    input  logic [7:0] usb_dout,
    input  logic       usb_oe,
    input  logic       eth_req,
    input  logic       eth_done,
    output logic       eth_gnt,
    input  logic [7:0] eth_dout,
    input  logic       eth_oe,
    inout  wire  [7:0] shared_d,
    output logic [7:0] shared_din,
    output logic [1:0] bus_owner,
    output logic       timeout_flag,
    output logic       timeout_src,
    input  logic       timeout_clr
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD_CYCLES);
    localparam int unsigned TURN_W = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_LAST =
        TURN_W'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);
    localparam arb_state_e REL_STATE = (TURNAROUND_CYCLES > 0) ? TURN : IDLE;

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              last_eth_q, last_eth_d;
    logic              tflag_q, tflag_d;
    logic              tsrc_q, tsrc_d;
    logic              tflag_set;
    logic              usb_gnt_q, eth_gnt_q;
    BusOwner_t         owner_q;
    logic              hold_exp_c;
    logic              usb_drive_c, eth_drive_c;

    assign hold_exp_c = (hold_q == HOLD_LAST);

    // Next-state: round-robin on ties, release on done / dropped req / watchdog
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        last_eth_d = last_eth_q;
        tsrc_d     = tsrc_q;
        tflag_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (usb_req && (!eth_req || last_eth_q)) begin
                    state_d    = GNT_USB;
                    hold_d     = '0;
                    last_eth_d = 1'b0;
                end else if (eth_req) begin
                    state_d    = GNT_ETH;
                    hold_d     = '0;
                    last_eth_d = 1'b1;
                end
            end
            GNT_USB: begin
                if (usb_done || !usb_req || hold_exp_c) begin
                    state_d = REL_STATE;
                    turn_d  = '0;
                    if (!usb_done && usb_req) begin
                        tflag_set = 1'b1;
                        tsrc_d    = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GNT_ETH: begin
                if (eth_done || !eth_req || hold_exp_c) begin
                    state_d = REL_STATE;
                    turn_d  = '0;
                    if (!eth_done && eth_req) begin
                        tflag_set = 1'b1;
                        tsrc_d    = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A watchdog hit wins over a clear arriving in the same cycle
        tflag_d = tflag_set | (tflag_q & ~timeout_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            turn_q     <= '0;
            last_eth_q <= 1'b1;
            tflag_q    <= 1'b0;
            tsrc_q     <= 1'b0;
            usb_gnt_q  <= 1'b0;
            eth_gnt_q  <= 1'b0;
            owner_q    <= OWNER_NONE;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            last_eth_q <= last_eth_d;
            tflag_q    <= tflag_d;
            tsrc_q     <= tsrc_d;
            usb_gnt_q  <= (state_d == GNT_USB);
            eth_gnt_q  <= (state_d == GNT_ETH);
            owner_q    <= (state_d == GNT_USB) ? OWNER_USB :
                          (state_d == GNT_ETH) ? OWNER_ETH : OWNER_NONE;
        end
    end

    // Pad enables are mutually exclusive because state_q is one-hot in effect
    assign usb_drive_c = (state_q == GNT_USB) && usb_gnt_q && usb_oe;
    assign eth_drive_c = (state_q == GNT_ETH) && eth_gnt_q && eth_oe;
    assign shared_d    = usb_drive_c ? usb_dout :
                         eth_drive_c ? eth_dout : 8'hzz;
    assign shared_din  = shared_d;

    assign usb_gnt      = usb_gnt_q;
    assign eth_gnt      = eth_gnt_q;
    assign bus_owner    = owner_q;
    assign timeout_flag = tflag_q;
    assign timeout_src  = tsrc_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed self-checking bench for ext_bus_arbiter (default parameters).
module tb_ext_bus_arbiter;

    logic       clk, rst;
    logic       usb_req, usb_done, usb_oe, eth_req, eth_done, eth_oe;
    logic [7:0] usb_dout, eth_dout;
    logic       usb_gnt, eth_gnt;
    logic [7:0] shared_din;
    logic [1:0] bus_owner;
    logic       timeout_flag, timeout_src, timeout_clr;
    logic       tb_drv_en;
    logic [7:0] tb_drv;
    wire  [7:0] shared_d;

    int n_tests = 0;
    int n_fail  = 0;

    // The bench drives a marker onto the pad only where the DUT must be off
    assign shared_d = tb_drv_en ? tb_drv : 8'hzz;

    ext_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .usb_req(usb_req), .usb_done(usb_done), .usb_gnt(usb_gnt),
        .usb_dout(usb_dout), .usb_oe(usb_oe),
        .eth_req(eth_req), .eth_done(eth_done), .eth_gnt(eth_gnt),
        .eth_dout(eth_dout), .eth_oe(eth_oe),
        .shared_d(shared_d), .shared_din(shared_din), .bus_owner(bus_owner),
        .timeout_flag(timeout_flag), .timeout_src(timeout_src),
        .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Marker must read back unchanged, proving nobody else drives the pad
    task automatic check_pad_free(input string tag);
        tb_drv    = 8'h5A;
        tb_drv_en = 1'b1;
        #1;
        check(tag, 16'(shared_din), 16'h005A);
        tb_drv_en = 1'b0;
    endtask

    initial begin
        clk = 0; rst = 1; tb_drv_en = 0; tb_drv = 0;
        usb_req = 0; usb_done = 0; usb_oe = 0; usb_dout = 0;
        eth_req = 0; eth_done = 0; eth_oe = 0; eth_dout = 0; timeout_clr = 0;
        #12;
        check("rst_usb_gnt", 16'(usb_gnt), 16'd0);
        check("rst_eth_gnt", 16'(eth_gnt), 16'd0);
        check("rst_owner", 16'(bus_owner), 16'd0);
        check("rst_tflag", 16'(timeout_flag), 16'd0);
        check("rst_tsrc", 16'(timeout_src), 16'd0);
        check_pad_free("rst_pad");
        @(posedge clk); #2; rst = 0;

        // USB only, with a stray eth_done while USB owns the bus
        usb_req = 1; #1;
        check("usb_gnt_lat0", 16'(usb_gnt), 16'd0);
        cyc(1);
        check("usb_gnt", 16'(usb_gnt), 16'd1);
        check("usb_owner", 16'(bus_owner), 16'd1);
        usb_oe = 1; usb_dout = 8'hA5; eth_done = 1; #1;
        check("usb_pad", 16'(shared_din), 16'h00A5);
        cyc(1); eth_done = 0;
        check("stray_usb_gnt", 16'(usb_gnt), 16'd1);
        check("stray_eth_gnt", 16'(eth_gnt), 16'd0);
        cyc(2); usb_done = 1;
        cyc(1);
        check("usb_rel_gnt", 16'(usb_gnt), 16'd0);
        check("usb_rel_owner", 16'(bus_owner), 16'd0);
        usb_done = 0; usb_req = 0;
        check_pad_free("usb_rel_pad");
        cyc(3);

        // Turnaround: ETH waiting while USB owns the bus
        usb_req = 1; cyc(1);
        eth_req = 1; cyc(1);
        check("ta_usb_hold", 16'(usb_gnt), 16'd1);
        check("ta_eth_wait", 16'(eth_gnt), 16'd0);
        usb_done = 1; cyc(1);
        check("ta_m1_usb", 16'(usb_gnt), 16'd0);
        check("ta_m1_eth", 16'(eth_gnt), 16'd0);
        usb_done = 0; usb_req = 0;
        check_pad_free("ta_m1_pad");
        cyc(1);
        check("ta_m2_eth", 16'(eth_gnt), 16'd0);
        check_pad_free("ta_m2_pad");
        cyc(1);
        check("ta_m3_eth", 16'(eth_gnt), 16'd0);
        cyc(1);
        check("ta_m4_eth", 16'(eth_gnt), 16'd1);
        check("ta_m4_owner", 16'(bus_owner), 16'd2);

        // Ties alternate: last owner ETH -> USB first
        eth_done = 1; cyc(1); eth_done = 0;
        usb_req = 1; cyc(3);
        check("tie1_usb", 16'(usb_gnt), 16'd1);
        check("tie1_eth", 16'(eth_gnt), 16'd0);
        usb_done = 1; cyc(1); usb_done = 0; usb_req = 0;
        cyc(3);
        check("tie1_eth_next", 16'(eth_gnt), 16'd1);
        eth_done = 1; cyc(1); eth_done = 0;
        usb_req = 1; cyc(3);
        check("tie2_usb", 16'(usb_gnt), 16'd1);
        check("tie2_eth", 16'(eth_gnt), 16'd0);

        // Implicit release by dropping usb_req
        usb_req = 0; cyc(1);
        check("impl_usb_gnt", 16'(usb_gnt), 16'd0);
        check("impl_tflag", 16'(timeout_flag), 16'd0);
        cyc(3);
        check("wd_eth_gnt", 16'(eth_gnt), 16'd1);

        // ETH watchdog: grant lasts exactly 64 cycles
        cyc(62);
        check("wd_eth_63", 16'(eth_gnt), 16'd1);
        check("wd_flag_63", 16'(timeout_flag), 16'd0);
        cyc(1);
        check("wd_eth_64", 16'(eth_gnt), 16'd1);
        cyc(1);
        check("wd_eth_65", 16'(eth_gnt), 16'd0);
        check("wd_flag", 16'(timeout_flag), 16'd1);
        check("wd_src_eth", 16'(timeout_src), 16'd1);
        eth_req = 0; timeout_clr = 1; usb_req = 1;
        cyc(1); timeout_clr = 0;
        check("clr_flag", 16'(timeout_flag), 16'd0);

        // USB watchdog with a clear in the same cycle: set wins
        cyc(2);
        check("wd2_usb_gnt", 16'(usb_gnt), 16'd1);
        cyc(63);
        check("wd2_usb_64", 16'(usb_gnt), 16'd1);
        timeout_clr = 1; cyc(1); timeout_clr = 0;
        check("wd2_usb_rel", 16'(usb_gnt), 16'd0);
        check("wd2_flag", 16'(timeout_flag), 16'd1);
        check("wd2_src_usb", 16'(timeout_src), 16'd0);
        usb_req = 0;
        cyc(1);
        check("wd2_flag_hold", 16'(timeout_flag), 16'd1);

        // Asynchronous reset while ETH drives the pad
        eth_req = 1; cyc(2);
        check("rm_eth_gnt", 16'(eth_gnt), 16'd1);
        eth_oe = 1; eth_dout = 8'h3C; #1;
        check("rm_eth_pad", 16'(shared_din), 16'h003C);
        usb_req = 1; #1;
        rst = 1; #1;
        check("rm_eth_drop", 16'(eth_gnt), 16'd0);
        check("rm_owner", 16'(bus_owner), 16'd0);
        check("rm_tflag", 16'(timeout_flag), 16'd0);
        check_pad_free("rm_pad");
        @(posedge clk); #2; rst = 0;
        cyc(1);
        check("rm_tie_usb", 16'(usb_gnt), 16'd1);
        check("rm_tie_eth", 16'(eth_gnt), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
